// File: rtl/nines_rom_sequencer.sv
// Two-requester burst-read controller for the nines lookup ROM.
// Arbitrates round-robin between requesters 0 and 1. For each granted burst it drives
// the ROM strobes for ACCESS_CYCLES cycles per byte and captures the byte. Each byte is
// then presented on a valid/ready stream tagged with the owning requester.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req{0,1}_i               burst request, held until the matching grant
//   start{0,1}_i, len{0,1}_i first address and byte count (0 = empty burst)
//   gnt{0,1}_o               one-cycle grant pulse
//   rom_addr_o, rom_cs_n_o,  ROM address and active-low strobes
//   rom_oe_n_o, rom_data_i   ROM read data (asynchronous)
//   rd_data_o, rd_valid_o,   captured byte stream; rd_last_o marks the final byte
//   rd_ready_i, rd_id_o,
//   rd_last_o
//   done_o, done_id_o        one-cycle burst-complete pulse and its requester
//   busy_o                   controller not idle
// All outputs are registered.
module nines_rom_sequencer #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned ADDR_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] start0_i,
  input  logic [ADDR_W-1:0] start1_i,
  input  logic [7:0]        len0_i,
  input  logic [7:0]        len1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_cs_n_o,
  output logic              rom_oe_n_o,
  input  logic [7:0]        rom_data_i,
  output logic [7:0]        rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              rd_id_o,
  output logic              rd_last_o,
  output logic              done_o,
  output logic              done_id_o,
  output logic              busy_o
);

  // StGrant is the cycle the grant pulse is visible; strobes follow one cycle later,
  // which puts the first byte ACCESS_CYCLES+1 cycles after the grant edge.
  typedef enum logic [2:0] {StIdle, StGrant, StAccess, StOutput, StDone} state_e;

  localparam logic [3:0] WaitLast = 4'(ACCESS_CYCLES - 1);

  state_e            state_q, state_d;
  logic              last_served_q, last_served_d;
  logic              cur_id_q, cur_id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        remaining_q, remaining_d;
  logic [3:0]        wait_q, wait_d;
  logic              cs_n_q, cs_n_d;
  logic              oe_n_q, oe_n_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_id_q, rd_id_d;
  logic              rd_last_q, rd_last_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done_q, done_d;
  logic              done_id_q, done_id_d;
  logic              busy_q, busy_d;
  logic              pick1;

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    cur_id_d      = cur_id_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    wait_d        = wait_q;
    cs_n_d        = cs_n_q;
    oe_n_d        = oe_n_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_valid_q;
    rd_id_d       = rd_id_q;
    rd_last_d     = rd_last_q;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    done_d        = 1'b0;
    done_id_d     = done_id_q;
    pick1         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          // On a tie, the requester that was not served last wins.
          pick1         = req1_i && (!req0_i || !last_served_q);
          cur_id_d      = pick1;
          last_served_d = pick1;
          addr_d        = pick1 ? start1_i : start0_i;
          remaining_d   = pick1 ? len1_i : len0_i;
          gnt0_d        = !pick1;
          gnt1_d        = pick1;
          state_d       = StGrant;
        end
      end
      StGrant: begin
        if (remaining_q == 8'd0) begin
          done_d    = 1'b1;
          done_id_d = cur_id_q;
          state_d   = StDone;
        end else begin
          cs_n_d  = 1'b0;
          oe_n_d  = 1'b0;
          wait_d  = 4'd0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (wait_q == WaitLast) begin
          rd_data_d  = rom_data_i;
          rd_valid_d = 1'b1;
          rd_id_d    = cur_id_q;
          rd_last_d  = (remaining_q == 8'd1);
          cs_n_d     = 1'b1;
          oe_n_d     = 1'b1;
          state_d    = StOutput;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StOutput: begin
        if (rd_ready_i) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (remaining_q == 8'd1) begin
            done_d    = 1'b1;
            done_id_d = cur_id_q;
            state_d   = StDone;
          end else begin
            remaining_d = remaining_q - 8'd1;
            // Wraps from all-ones to zero within a burst.
            addr_d      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            cs_n_d      = 1'b0;
            oe_n_d      = 1'b0;
            wait_d      = 4'd0;
            state_d     = StAccess;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      last_served_q <= 1'b1;
      cur_id_q      <= 1'b0;
      addr_q        <= '0;
      remaining_q   <= 8'd0;
      wait_q        <= 4'd0;
      cs_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      rd_data_q     <= 8'd0;
      rd_valid_q    <= 1'b0;
      rd_id_q       <= 1'b0;
      rd_last_q     <= 1'b0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      done_q        <= 1'b0;
      done_id_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      cur_id_q      <= cur_id_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      wait_q        <= wait_d;
      cs_n_q        <= cs_n_d;
      oe_n_q        <= oe_n_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_id_q       <= rd_id_d;
      rd_last_q     <= rd_last_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      done_q        <= done_d;
      done_id_q     <= done_id_d;
      busy_q        <= busy_d;
    end
  end

  assign gnt0_o     = gnt0_q;
  assign gnt1_o     = gnt1_q;
  assign rom_addr_o = addr_q;
  assign rom_cs_n_o = cs_n_q;
  assign rom_oe_n_o = oe_n_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_id_o    = rd_id_q;
  assign rd_last_o  = rd_last_q;
  assign done_o     = done_q;
  assign done_id_o  = done_id_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_nines_rom_sequencer.sv
// Directed bench for nines_rom_sequencer with ACCESS_CYCLES=2 and a ROM model
// returning mem[a] = a[7:0] + 1.
module tb_nines_rom_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] start0, start1;
  logic [7:0]  len0, len1;
  logic        gnt0, gnt1;
  logic [15:0] rom_addr;
  logic        rom_cs_n, rom_oe_n;
  logic [7:0]  rom_data;
  logic [7:0]  rd_data;
  logic        rd_valid, rd_ready, rd_id, rd_last;
  logic        done, done_id, busy;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  nines_rom_sequencer #(
    .ACCESS_CYCLES(2),
    .ADDR_W       (16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req0_i     (req0),
    .req1_i     (req1),
    .start0_i   (start0),
    .start1_i   (start1),
    .len0_i     (len0),
    .len1_i     (len1),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1),
    .rom_addr_o (rom_addr),
    .rom_cs_n_o (rom_cs_n),
    .rom_oe_n_o (rom_oe_n),
    .rom_data_i (rom_data),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .rd_ready_i (rd_ready),
    .rd_id_o    (rd_id),
    .rd_last_o  (rd_last),
    .done_o     (done),
    .done_id_o  (done_id),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = rom_addr[7:0] + 8'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    while (!(gnt0 || gnt1) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_gnt_seen"}, 32'(gnt0 | gnt1), 32'd1);
  endtask

  // Waits for a byte and checks it; rd_ready high makes the next edge accept it.
  task automatic get_byte(input string tag, input logic [7:0] d, input logic last,
                          input logic id, input logic [15:0] a);
    int n;
    n = 0;
    while (!rd_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(d));
    chk({tag, "_last"}, 32'(rd_last), 32'(last));
    chk({tag, "_id"}, 32'(rd_id), 32'(id));
    chk({tag, "_addr"}, 32'(rom_addr), 32'(a));
    chk({tag, "_csn"}, 32'(rom_cs_n), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    start0 = 16'h0; start1 = 16'h0; len0 = 8'd0; len1 = 8'd0; rd_ready = 1'b1;
    #12;
    // Reset values.
    chk("rst_csn", 32'(rom_cs_n), 32'd1);
    chk("rst_oen", 32'(rom_oe_n), 32'd1);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic 3-byte burst with exact timing.
    req0 = 1'b1; start0 = 16'h0010; len0 = 8'd3;
    tick();  // grant edge
    chk("t1_gnt0", 32'(gnt0), 32'd1);
    chk("t1_gnt1", 32'(gnt1), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_csn_gntcyc", 32'(rom_cs_n), 32'd1);
    req0 = 1'b0;
    tick();
    chk("t1_gnt0_off", 32'(gnt0), 32'd0);
    chk("t1_csn_low", 32'(rom_cs_n), 32'd0);
    chk("t1_oen_low", 32'(rom_oe_n), 32'd0);
    chk("t1_addr0", 32'(rom_addr), 32'h10);
    tick();
    chk("t1_csn_low2", 32'(rom_cs_n), 32'd0);
    chk("t1_novalid", 32'(rd_valid), 32'd0);
    tick();  // third edge after grant
    chk("t1_lat_valid", 32'(rd_valid), 32'd1);
    get_byte("t1_b0", 8'h11, 1'b0, 1'b0, 16'h0010);
    tick();
    chk("t1_drop", 32'(rd_valid), 32'd0);
    chk("t1_addr1", 32'(rom_addr), 32'h11);
    chk("t1_csn_b1", 32'(rom_cs_n), 32'd0);
    tick();
    tick();
    chk("t1_thru", 32'(rd_valid), 32'd1);
    get_byte("t1_b1", 8'h12, 1'b0, 1'b0, 16'h0011);
    tick();
    get_byte("t1_b2", 8'h13, 1'b1, 1'b0, 16'h0012);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_done_id", 32'(done_id), 32'd0);
    chk("t1_valid_off", 32'(rd_valid), 32'd0);
    tick();
    chk("t1_done_off", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Round-robin from reset with both requesting.
    rst_n = 1'b0;
    req0 = 1'b1; start0 = 16'h0030; len0 = 8'd1;
    req1 = 1'b1; start1 = 16'h0040; len1 = 8'd1;
    tick();
    rst_n = 1'b1;
    wait_gnt("t2a");
    chk("t2a_gnt0", 32'({gnt0, gnt1}), 32'b10);
    req0 = 1'b0;
    get_byte("t2a_b", 8'h31, 1'b1, 1'b0, 16'h0030);
    tick();
    chk("t2a_done_id", 32'({done, done_id}), 32'b10);
    wait_gnt("t2b");
    chk("t2b_gnt1", 32'({gnt0, gnt1}), 32'b01);
    req1 = 1'b0;
    get_byte("t2b_b", 8'h41, 1'b1, 1'b1, 16'h0040);
    tick();
    chk("t2b_done_id", 32'({done, done_id}), 32'b11);
    tick();
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt("t2c");
    chk("t2c_gnt0", 32'({gnt0, gnt1}), 32'b10);
    req0 = 1'b0;
    get_byte("t2c_b", 8'h31, 1'b1, 1'b0, 16'h0030);
    wait_gnt("t2d");
    chk("t2d_gnt1", 32'({gnt0, gnt1}), 32'b01);
    req1 = 1'b0;
    get_byte("t2d_b", 8'h41, 1'b1, 1'b1, 16'h0040);
    tick();
    tick();

    // Backpressure holds the byte and the address.
    req0 = 1'b1; start0 = 16'h0020; len0 = 8'd2;
    wait_gnt("t3");
    req0 = 1'b0;
    get_byte("t3_b0", 8'h21, 1'b0, 1'b0, 16'h0020);
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", 32'(rd_valid), 32'd1);
      chk("t3_hold_data", 32'(rd_data), 32'h21);
      chk("t3_hold_last", 32'(rd_last), 32'd0);
      chk("t3_hold_csn", 32'({rom_cs_n, rom_oe_n}), 32'b11);
      chk("t3_hold_addr", 32'(rom_addr), 32'h20);
    end
    rd_ready = 1'b1;
    tick();
    chk("t3_adv_addr", 32'(rom_addr), 32'h21);
    chk("t3_adv_valid", 32'(rd_valid), 32'd0);
    get_byte("t3_b1", 8'h22, 1'b1, 1'b0, 16'h0021);
    tick();
    chk("t3_done", 32'({done, done_id}), 32'b10);
    tick();

    // Address wrap within a burst.
    req1 = 1'b1; start1 = 16'hFFFE; len1 = 8'd3;
    wait_gnt("t4");
    chk("t4_gnt1", 32'({gnt0, gnt1}), 32'b01);
    req1 = 1'b0;
    get_byte("t4_b0", 8'hFF, 1'b0, 1'b1, 16'hFFFE);
    tick();
    get_byte("t4_b1", 8'h00, 1'b0, 1'b1, 16'hFFFF);
    tick();
    get_byte("t4_b2", 8'h01, 1'b1, 1'b1, 16'h0000);
    tick();
    chk("t4_done", 32'({done, done_id}), 32'b11);
    tick();

    // Empty burst: grant then done, no strobes.
    req0 = 1'b1; start0 = 16'h0070; len0 = 8'd0;
    wait_gnt("t5");
    chk("t5_gnt0", 32'({gnt0, gnt1}), 32'b10);
    chk("t5_nodone", 32'(done), 32'd0);
    chk("t5_csn_a", 32'(rom_cs_n), 32'd1);
    req0 = 1'b0;
    tick();
    chk("t5_done", 32'({done, done_id}), 32'b10);
    chk("t5_gnt_off", 32'(gnt0), 32'd0);
    chk("t5_csn_b", 32'(rom_cs_n), 32'd1);
    tick();
    chk("t5_idle", 32'({done, busy}), 32'b00);

    // Asynchronous reset during the second access of a 4-byte burst.
    req0 = 1'b1; start0 = 16'h0050; len0 = 8'd4;
    wait_gnt("t6");
    req0 = 1'b0;
    get_byte("t6_b0", 8'h51, 1'b0, 1'b0, 16'h0050);
    tick();
    chk("t6_csn_acc2", 32'(rom_cs_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_strobes", 32'({rom_cs_n, rom_oe_n}), 32'b11);
    chk("t6_rst_addr", 32'(rom_addr), 32'd0);
    chk("t6_rst_data", 32'(rd_data), 32'd0);
    chk("t6_rst_flags", 32'({rd_valid, rd_id, rd_last, busy}), 32'd0);
    tick();
    chk("t6_rst_nodone", 32'({done, done_id, gnt0, gnt1}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t6_post_nodone", 32'(done), 32'd0);
    req1 = 1'b1; start1 = 16'h0060; len1 = 8'd1;
    wait_gnt("t6r");
    chk("t6r_gnt1", 32'({gnt0, gnt1}), 32'b01);
    req1 = 1'b0;
    get_byte("t6r_b", 8'h61, 1'b1, 1'b1, 16'h0060);
    tick();
    chk("t6r_done", 32'({done, done_id}), 32'b11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
